// File: rtl/top_rtl_core.sv
// Self-checking traffic block: an LFSR producer fills a show-ahead FIFO, and a
// consumer drains it under a fixed 3-of-4 backpressure pattern against a reference LFSR.
`timescale 1ns/1ps
module top_rtl_core #(
    parameter int unsigned          DATA_W        = 32,
    parameter int unsigned          FIFO_DEPTH    = 8,
    parameter logic [DATA_W-1:0]    SEED          = 32'h0000_0001,
    parameter int unsigned          INJECT_ERR_AT = 0
) (
    input  logic                          i_clk,
    input  logic                          reset_n,
    output logic [31:0]                   o_xfer_cnt,
    output logic [15:0]                   o_err_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_pass
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;

    function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] d);
        return {d[DATA_W-2:0], d[31] ^ d[21] ^ d[1] ^ d[0]};
    endfunction

    logic [15:0]       cyc_q,      cyc_d;
    logic [AW-1:0]     wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q,   rd_ptr_d;
    logic [LW-1:0]     level_q,    level_d;
    logic [DATA_W-1:0] prod_q,     prod_d;
    logic [DATA_W-1:0] ref_q,      ref_d;
    logic [31:0]       push_cnt_q, push_cnt_d;
    logic [31:0]       xfer_q,     xfer_d;
    logic [15:0]       err_q,      err_d;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] head;

    always_comb begin
        full  = (level_q == LW'(FIFO_DEPTH));
        empty = (level_q == '0);
        push  = !full;
        pop   = !empty && (cyc_q[1:0] != 2'b11);
        head  = mem_q[rd_ptr_q];

        // push_cnt_q counts completed pushes, so this push has index push_cnt_q+1
        wdata = prod_q;
        if ((INJECT_ERR_AT != 0) && ((push_cnt_q + 32'd1) == INJECT_ERR_AT)) begin
            wdata[0] = ~prod_q[0];
        end
    end

    always_comb begin
        cyc_d      = cyc_q + 16'd1;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        prod_d     = prod_q;
        ref_d      = ref_q;
        push_cnt_d = push_cnt_q;
        xfer_d     = xfer_q;
        err_d      = err_q;

        if (push) begin
            wr_ptr_d   = wr_ptr_q + AW'(1);
            prod_d     = lfsr_step(prod_q);
            push_cnt_d = push_cnt_q + 32'd1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            ref_d    = lfsr_step(ref_q);
            xfer_d   = xfer_q + 32'd1;
            if ((head != ref_q) && (err_q != '1)) begin
                err_d = err_q + 16'd1;
            end
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            prod_q     <= SEED;
            ref_q      <= SEED;
            push_cnt_q <= '0;
            xfer_q     <= '0;
            err_q      <= '0;
        end else begin
            cyc_q      <= cyc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            prod_q     <= prod_d;
            ref_q      <= ref_d;
            push_cnt_q <= push_cnt_d;
            xfer_q     <= xfer_d;
            err_q      <= err_d;
        end
    end

    // Storage needs no reset: a cleared level makes stale entries unreachable.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign o_xfer_cnt   = xfer_q;
    assign o_err_cnt    = err_q;
    assign o_fifo_level = level_q;
    assign o_pass       = (err_q == '0) && (xfer_q != '0);

endmodule

// File: tb/tb_top_rtl_core.sv
// Bench for top_rtl_core: a clean instance and an error-injecting instance run
// side by side against a queue-based transaction model of the traffic block.
`timescale 1ns/1ps
module tb_top_rtl_core;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned INJ   = 5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic [31:0] xfer_a, xfer_b;
    logic [15:0] err_a,  err_b;
    logic [3:0]  lvl_a,  lvl_b;
    logic        pass_a, pass_b;

    int checks = 0;
    int errors = 0;

    top_rtl_core #(.FIFO_DEPTH(DEPTH), .SEED(32'h0000_0001), .INJECT_ERR_AT(0)) u_dut (
        .i_clk(clk), .reset_n(reset_n), .o_xfer_cnt(xfer_a), .o_err_cnt(err_a),
        .o_fifo_level(lvl_a), .o_pass(pass_a)
    );

    top_rtl_core #(.FIFO_DEPTH(DEPTH), .SEED(32'h0000_0001), .INJECT_ERR_AT(INJ)) u_inj (
        .i_clk(clk), .reset_n(reset_n), .o_xfer_cnt(xfer_b), .o_err_cnt(err_b),
        .o_fifo_level(lvl_b), .o_pass(pass_b)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Transaction model: FIFO entries carry the clean word and their push index,
    // so the injecting instance's corruption is applied only when it is popped.
    typedef struct {
        logic [31:0] word;
        int unsigned idx;
    } entry_t;

    entry_t      m_q[$];
    logic [31:0] m_prod, m_ref, m_xfer, m_last_pop;
    int unsigned m_pushes, m_cyc, m_err0, m_err1;

    function automatic logic [31:0] lfsr_next(input logic [31:0] d);
        return {d[30:0], d[31] ^ d[21] ^ d[1] ^ d[0]};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_prod = 32'h1; m_ref = 32'h1; m_xfer = '0; m_last_pop = '0;
        m_pushes = 0; m_cyc = 0; m_err0 = 0; m_err1 = 0;
    endtask

    task automatic model_edge();
        bit do_push, do_pop;
        entry_t e;
        logic [31:0] w1;
        do_push = (m_q.size() < DEPTH);
        do_pop  = (m_q.size() > 0) && ((m_cyc % 4) != 3);
        if (do_pop) begin
            e  = m_q.pop_front();
            w1 = (e.idx == INJ) ? (e.word ^ 32'h1) : e.word;
            if (e.word != m_ref && m_err0 < 65535) m_err0++;
            if (w1 != m_ref && m_err1 < 65535) m_err1++;
            m_ref = lfsr_next(m_ref);
            m_xfer = m_xfer + 32'd1;
            m_last_pop = e.word;
        end
        if (do_push) begin
            m_pushes++;
            e.word = m_prod;
            e.idx  = m_pushes;
            m_q.push_back(e);
            m_prod = lfsr_next(m_prod);
        end
        m_cyc = (m_cyc + 1) % 65536;
    endtask

    // Every edge passes through here; outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
        if (reset_n) model_edge();
    endtask

    task automatic assert_reset();
        #2;
        reset_n = 1'b0;
        model_reset();
    endtask

    task automatic release_reset();
        #2;
        reset_n = 1'b1;
    endtask

    task automatic restart();
        assert_reset();
        repeat (2) tick();
        release_reset();
    endtask

    task automatic test_reset();
        model_reset();
        repeat (10) tick();
        checks++; if (xfer_a !== 32'd0) begin errors++; $display("FAIL reset_xfer: got %0d expected 0", xfer_a); end
        checks++; if (err_a !== 16'd0 || err_b !== 16'd0) begin errors++; $display("FAIL reset_err: got %0d/%0d expected 0", err_a, err_b); end
        checks++; if (lvl_a !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", lvl_a); end
        checks++; if (pass_a !== 1'b0 || pass_b !== 1'b0) begin errors++; $display("FAIL reset_pass: got %0b/%0b expected 0", pass_a, pass_b); end

        release_reset();
        repeat (20) tick();
        checks++; if (xfer_a !== m_xfer) begin errors++; $display("FAIL pre_async_xfer: got %0d expected %0d", xfer_a, m_xfer); end
        // Reset lands 3 ns after an edge and is sampled 1 ns later, before any edge.
        assert_reset();
        #1;
        checks++; if (xfer_a !== 32'd0 || xfer_b !== 32'd0) begin errors++; $display("FAIL async_xfer: got %0d/%0d expected 0", xfer_a, xfer_b); end
        checks++; if (lvl_a !== 4'd0 || lvl_b !== 4'd0) begin errors++; $display("FAIL async_level: got %0d/%0d expected 0", lvl_a, lvl_b); end
        checks++; if (pass_a !== 1'b0) begin errors++; $display("FAIL async_pass: got %0b expected 0", pass_a); end
        tick();
    endtask

    task automatic test_sequence();
        release_reset();
        tick();
        checks++; if (lvl_a !== 4'd1) begin errors++; $display("FAIL seq_first_level: got %0d expected 1", lvl_a); end
        checks++; if (xfer_a !== 32'd0 || pass_a !== 1'b0) begin errors++; $display("FAIL seq_first_xfer: got %0d pass %0b expected 0 pass 0", xfer_a, pass_a); end
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++; if (xfer_a !== m_xfer) begin errors++; $display("FAIL seq_xfer_%0d: got %0d expected %0d", k, xfer_a, m_xfer); end
            checks++; if (err_a !== 16'd0) begin errors++; $display("FAIL seq_err_%0d: got %0d expected 0", k, err_a); end
            checks++; if (pass_a !== 1'b1) begin errors++; $display("FAIL seq_pass_%0d: got %0b expected 1", k, pass_a); end
            checks++; if (lvl_a !== 4'(m_q.size())) begin errors++; $display("FAIL seq_level_%0d: got %0d expected %0d", k, lvl_a, m_q.size()); end
        end
    endtask

    task automatic test_throughput();
        repeat (96) tick();
        checks++; if (xfer_a !== 32'd74) begin errors++; $display("FAIL throughput_xfer: got %0d expected 74", xfer_a); end
        checks++; if (err_a !== 16'd0) begin errors++; $display("FAIL throughput_err: got %0d expected 0", err_a); end
        checks++; if (xfer_a !== m_xfer) begin errors++; $display("FAIL throughput_model: got %0d expected %0d", xfer_a, m_xfer); end
    endtask

    task automatic test_fifo_full();
        restart();
        for (int k = 0; k < 1000; k++) begin
            tick();
            checks++; if (lvl_a !== 4'(m_q.size())) begin errors++; $display("FAIL full_level_%0d: got %0d expected %0d", k, lvl_a, m_q.size()); end
            if (k == 27) begin
                checks++; if (lvl_a !== 4'd8) begin errors++; $display("FAIL full_reach: got %0d expected 8", lvl_a); end
            end else if (k > 27) begin
                checks++; if (lvl_a !== 4'd7 && lvl_a !== 4'd8) begin errors++; $display("FAIL full_band_%0d: got %0d expected 7 or 8", k, lvl_a); end
            end else begin
                checks++; if (lvl_a >= 4'd8) begin errors++; $display("FAIL full_early_%0d: got %0d expected below 8", k, lvl_a); end
            end
        end
        checks++; if (err_a !== 16'd0 || !pass_a) begin errors++; $display("FAIL full_no_loss: got err %0d pass %0b expected 0 and 1", err_a, pass_a); end
        checks++; if (xfer_a !== m_xfer) begin errors++; $display("FAIL full_xfer: got %0d expected %0d", xfer_a, m_xfer); end
    endtask

    task automatic test_error_inject();
        restart();
        for (int k = 0; k < 1000; k++) begin
            tick();
            checks++; if (err_b !== 16'(m_err1)) begin errors++; $display("FAIL inj_err_%0d: got %0d expected %0d", k, err_b, m_err1); end
            checks++; if (pass_b !== (m_err1 == 0 && m_xfer != 0)) begin errors++; $display("FAIL inj_pass_%0d: got %0b expected %0b", k, pass_b, (m_err1 == 0 && m_xfer != 0)); end
            if (k == 5) begin
                checks++; if (err_b !== 16'd0 || pass_b !== 1'b1) begin errors++; $display("FAIL inj_before: got err %0d pass %0b expected 0 and 1", err_b, pass_b); end
            end
            if (k == 6) begin
                checks++; if (err_b !== 16'd1 || pass_b !== 1'b0) begin errors++; $display("FAIL inj_at_pop5: got err %0d pass %0b expected 1 and 0", err_b, pass_b); end
            end
        end
        checks++; if (err_b !== 16'd1) begin errors++; $display("FAIL inj_final: got %0d expected 1", err_b); end
        checks++; if (err_a !== 16'd0) begin errors++; $display("FAIL inj_clean_peer: got %0d expected 0", err_a); end
    endtask

    task automatic test_reset_midrun();
        restart();
        repeat (500) tick();
        assert_reset();
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (xfer_a !== 32'd0 || err_b !== 16'd0 || lvl_a !== 4'd0) begin errors++; $display("FAIL mid_cleared_%0d: got xfer %0d err %0d level %0d expected 0", k, xfer_a, err_b, lvl_a); end
        end
        release_reset();
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++; if (xfer_a !== m_xfer) begin errors++; $display("FAIL mid_xfer_%0d: got %0d expected %0d", k, xfer_a, m_xfer); end
            checks++; if (err_a !== 16'd0) begin errors++; $display("FAIL mid_err_%0d: got %0d expected 0", k, err_a); end
        end
        checks++; if (err_b !== 16'd1) begin errors++; $display("FAIL mid_inj_err: got %0d expected 1", err_b); end
    endtask

    task automatic test_random_resets();
        for (int r = 0; r < 6; r++) begin
            int unsigned run_len = $urandom_range(5, 200);
            int unsigned hold    = $urandom_range(1, 4);
            for (int unsigned k = 0; k < run_len; k++) begin
                tick();
                checks++; if (xfer_a !== m_xfer || xfer_b !== m_xfer) begin errors++; $display("FAIL rnd_xfer_%0d_%0d: got %0d/%0d expected %0d", r, k, xfer_a, xfer_b, m_xfer); end
                checks++; if (lvl_a !== 4'(m_q.size())) begin errors++; $display("FAIL rnd_level_%0d_%0d: got %0d expected %0d", r, k, lvl_a, m_q.size()); end
                checks++; if (err_a !== 16'(m_err0) || err_b !== 16'(m_err1)) begin errors++; $display("FAIL rnd_err_%0d_%0d: got %0d/%0d expected %0d/%0d", r, k, err_a, err_b, m_err0, m_err1); end
                checks++; if (pass_b !== (m_err1 == 0 && m_xfer != 0)) begin errors++; $display("FAIL rnd_pass_%0d_%0d: got %0b expected %0b", r, k, pass_b, (m_err1 == 0 && m_xfer != 0)); end
            end
            #($urandom_range(1, 7));
            reset_n = 1'b0;
            model_reset();
            #1;
            checks++; if (xfer_b !== 32'd0 || err_b !== 16'd0 || pass_b !== 1'b0) begin errors++; $display("FAIL rnd_async_%0d: got xfer %0d err %0d pass %0b expected 0", r, xfer_b, err_b, pass_b); end
            repeat (hold) tick();
            release_reset();
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_throughput();
        test_fifo_full();
        test_error_inject();
        test_reset_midrun();
        test_random_resets();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
